load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the CPU-side request address.
REQ-002 The block SHALL have parameter BUS_AW, default 6, meaning the byte-address width of the memory bus, giving a 64-byte window.
REQ-003 The block SHALL have port clock  in  1  sole clock; all state updates on posedge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  in  1  CPU request strobe.
REQ-006 The block SHALL have port req_ready  out  1  block can accept a request this cycle.
REQ-007 The block SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_length  in  2  size code: 00 none, 01 byte, 10 half, 11 word.
REQ-009 The block SHALL have port req_signed  in  1  sign-extend load result.
REQ-010 The block SHALL have port req_address  in  ADDR_W  byte address.
REQ-011 The block SHALL have port req_wdata  in  32  store data, right-justified.
REQ-012 The block SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-013 The block SHALL have port resp_rdata  out  32  load result, held until the next accept.
REQ-014 The block SHALL have port resp_error  out  1  misalignment flag, meaningful only when resp_valid is high.
REQ-015 The block SHALL have port bus_address  out  BUS_AW  byte address to memory.
REQ-016 The block SHALL have port bus_wdata  out  8  byte to write.
REQ-017 The block SHALL have port bus_rdata  in  8  combinational read byte from memory.
REQ-018 The block SHALL have port bus_read / bus_write  out  1 each  one-hot byte strobes.

Function
REQ-019 The FSM SHALL have the states IDLE, XFER and DONE; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with req_valid=1, the block SHALL capture all req_* signals, clear the beat counter, and go to XFER; with req_length=00 it SHALL go directly to DONE.
REQ-021 XFER SHALL issue N beats, one per cycle, where N=1/2/4 for byte/half/word.
REQ-022 Beat k SHALL use bus_address = (req_address[BUS_AW-1:0] + k) mod 2^BUS_AW, so the address wraps from 63 to 0.
REQ-023 Byte order SHALL be big-endian: beat 0 carries the most significant byte of the access.
REQ-024 For stores, beat k SHALL drive bus_write=1 with bus_wdata = req_wdata byte (N-1-k), counting bytes from the LSB.
REQ-025 For loads, beat k SHALL drive bus_read=1 and shift bus_rdata into an accumulator at the end of the cycle.
REQ-026 When the final beat completes, the FSM SHALL go to DONE; DONE SHALL assert resp_valid for exactly one cycle and then return to IDLE.
REQ-027 Latency SHALL be: accept at edge 0; beats in cycles 1..N; resp_valid in cycle N+1; next accept no earlier than cycle N+2.
REQ-028 Load results SHALL be extended as follows: byte/half sign-extended if req_signed, else zero-extended; word ignores req_signed; a length-00 load returns 0.
REQ-029 Store responses SHALL return resp_rdata = 0.
REQ-030 Outside XFER, bus_read, bus_write, bus_address and bus_wdata SHALL all be 0.
REQ-031 Requests presented while req_ready=0 SHALL be ignored, not queued.

Reset
REQ-032 With reset=0 at a posedge, the block SHALL enter IDLE with req_ready=1 and resp_valid, resp_rdata, resp_error and all bus outputs at 0.
REQ-033 Reset during XFER SHALL abandon the access with no response, and strobes SHALL be low from the next cycle; bytes already written are not rolled back.

Configuration
REQ-034 When LSU_MISALIGN_CHECK_EN is defined, a half access at an odd address or a word access with address[1:0]!=0 SHALL go IDLE->DONE with no bus beats, resp_error=1 and resp_rdata=0.
REQ-035 When LSU_MISALIGN_CHECK_EN is undefined, unaligned accesses SHALL proceed per REQ-022 and resp_error SHALL be tied to 0.

Structure
REQ-036 The shared package lsu_pkg SHALL hold the size-code constants LEN_NONE, LEN_BYTE, LEN_HALF and LEN_WORD and the FSM state enum.
REQ-037 Extension logic SHALL live in a single combinational sub-module, lsu_extend (inputs: raw 32-bit value, length, signed flag).

Verification
REQ-038 The bench SHALL cover: word store 0x12345678 at address 8 -> beats at addresses 8,9,10,11 with data 12,34,56,78; resp_valid in cycle 5.
REQ-039 The bench SHALL cover: memory bytes 0xF0,0x0F at 20/21, signed half load at 20 -> resp_rdata 0xFFFFF00F; unsigned -> 0x0000F00F.
REQ-040 The bench SHALL cover: unsigned byte load of 0x80 -> 0x00000080; signed -> 0xFFFFFF80; a single read beat.
REQ-041 The bench SHALL cover: half store 0xAABB at address 63, macro undefined -> writes 0xAA@63 and 0xBB@0; with macro defined -> no beats and resp_error=1.
REQ-042 The bench SHALL cover: reset low during beat 2 of a word store -> no resp_valid, only 0x12 and 0x34 written, req_ready=1 the cycle after reset releases.
REQ-043 The bench SHALL cover: req_valid held high through a load -> exactly one response, and a second accept only in cycle N+2.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, FSM state type and helpers for the load/store unit
// Contents:
//   LEN_NONE/LEN_BYTE/LEN_HALF/LEN_WORD : request size codes
//   lsu_state_e                         : IDLE / XFER / DONE
//   last_index(len)                     : index of the final bus beat for a size code
//   align_store(wdata, len)             : moves the store bytes so beat 0's byte sits in [31:24]
package lsu_pkg;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  function automatic logic [1:0] last_index(input logic [1:0] len);
    case (len)
      LEN_HALF: last_index = 2'd1;
      LEN_WORD: last_index = 2'd3;
      default:  last_index = 2'd0;
    endcase
  endfunction

  // Big-endian beat order: the most significant byte of the access goes out
  // first, so left-justify it and shift left one byte per beat.
  function automatic logic [31:0] align_store(input logic [31:0] wdata, input logic [1:0] len);
    case (len)
      LEN_BYTE: align_store = {wdata[7:0], 24'h000000};
      LEN_HALF: align_store = {wdata[15:0], 16'h0000};
      LEN_WORD: align_store = wdata;
      default:  align_store = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of an assembled load value
// Ports:
//   raw       in  32  bytes assembled from the bus, right-justified
//   length    in  2   size code (LEN_*)
//   is_signed in  1   sign-extend byte/half results
//   value     out 32  extended result (0 for LEN_NONE)
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  length,
  input  logic        is_signed,
  output logic [31:0] value
);

  always_comb begin
    value = 32'h0000_0000;
    case (length)
      LEN_BYTE: value = {{24{is_signed & raw[7]}}, raw[7:0]};
      LEN_HALF: value = {{16{is_signed & raw[15]}}, raw[15:0]};
      LEN_WORD: value = raw;
      default:  value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store requests serialised onto a big-endian byte bus
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject unaligned half/word accesses
// (no bus beats, resp_error=1); otherwise unaligned accesses proceed and resp_error is 0.
// Ports:
//   clock, reset (sync, active-low)
//   req_valid/req_ready handshake; req_write, req_length, req_signed, req_address, req_wdata
//   resp_valid (1-cycle pulse), resp_rdata (held until next accept), resp_error
//   bus_address, bus_wdata, bus_read, bus_write (one beat per cycle), bus_rdata (comb read)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BUS_AW = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_length,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [BUS_AW-1:0] bus_address,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  output logic              bus_read,
  output logic              bus_write
);

  lsu_state_e  state;
  logic        cap_write;
  logic [1:0]  cap_len;
  logic        cap_signed;
  logic [1:0]  beat;
  logic [1:0]  last_beat;
  logic [31:0] store_bytes;
  logic [23:0] acc;
  logic [31:0] acc_next;
  logic [31:0] ext_value;
  logic        misaligned;
  logic [31:0] store_aligned;

`ifdef LSU_MISALIGN_CHECK_EN
  logic error_q;
  assign misaligned = ((req_length == LEN_HALF) && req_address[0]) ||
                      ((req_length == LEN_WORD) && (req_address[1:0] != 2'b00));
  assign resp_error = error_q;
`else
  assign misaligned = 1'b0;
  assign resp_error = 1'b0;
`endif

  // Only the low BUS_AW address bits reach the bus window.
  if (ADDR_W > BUS_AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_address[ADDR_W-1:BUS_AW];
  end

  assign req_ready     = (state == IDLE);
  assign store_aligned = align_store(req_wdata, req_length);

  // Includes the byte being read this cycle, so the final beat's result is
  // complete when it is registered into resp_rdata.
  assign acc_next = {acc, bus_rdata};

  lsu_extend u_extend (
    .raw       (acc_next),
    .length    (cap_len),
    .is_signed (cap_signed),
    .value     (ext_value)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cap_write   <= 1'b0;
      cap_len     <= LEN_NONE;
      cap_signed  <= 1'b0;
      beat        <= 2'd0;
      last_beat   <= 2'd0;
      store_bytes <= 32'h0000_0000;
      acc         <= 24'h000000;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0000_0000;
      bus_address <= '0;
      bus_wdata   <= 8'h00;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      error_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_len    <= req_length;
            cap_signed <= req_signed;
            beat       <= 2'd0;
            last_beat  <= last_index(req_length);
            acc        <= 24'h000000;
            resp_rdata <= 32'h0000_0000;
            if ((req_length == LEN_NONE) || misaligned) begin
              // No bus traffic: respond on the next cycle with rdata 0.
              state      <= DONE;
              resp_valid <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
              error_q    <= misaligned;
`endif
            end else begin
              // Registered bus outputs: beat 0 is set up on the accept edge.
              state       <= XFER;
              bus_address <= req_address[BUS_AW-1:0];
              bus_write   <= req_write;
              bus_read    <= ~req_write;
              bus_wdata   <= req_write ? store_aligned[31:24] : 8'h00;
              store_bytes <= req_write ? store_aligned : 32'h0000_0000;
            end
          end
        end

        XFER: begin
          if (!cap_write) begin
            acc <= acc_next[23:0];
          end
          if (beat == last_beat) begin
            state       <= DONE;
            resp_valid  <= 1'b1;
            resp_rdata  <= cap_write ? 32'h0000_0000 : ext_value;
            bus_address <= '0;
            bus_wdata   <= 8'h00;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
          end else begin
            beat        <= beat + 2'd1;
            bus_address <= bus_address + BUS_AW'(1);
            bus_wdata   <= store_bytes[23:16];
            store_bytes <= {store_bytes[23:0], 8'h00};
          end
        end

        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
          error_q    <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte-memory model
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_length;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [5:0]  bus_address;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_read;
  logic        bus_write;

  logic [7:0]  mem [0:63];
  logic [31:0] last_rdata;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  assign bus_rdata = mem[bus_address];

  load_store_unit #(.ADDR_W(32), .BUS_AW(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_length  (req_length),
    .req_signed  (req_signed),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_read    (bus_read),
    .bus_write   (bus_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Number of bus beats the access should take.
  function automatic int n_beats(input logic [1:0] len, input logic [31:0] addr);
    int n;
    n = (len == 2'd0) ? 0 : (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : 4;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0)) n = 0;
`endif
    return n;
  endfunction

  function automatic logic exp_error(input logic [1:0] len, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    return (len == 2'd2 && addr % 2 != 0) || (len == 2'd3 && addr % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Big-endian read of n bytes with wrap at 64, then numeric sign handling.
  function automatic logic [31:0] model_load(input logic [1:0] len, input logic sgn,
                                             input logic [31:0] addr);
    int n;
    longint v;
    n = n_beats(len, addr);
    v = 0;
    for (int k = 0; k < n; k++) v = v * 256 + longint'(mem[(addr + k) % 64]);
    if (sgn && n > 0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Called just after a negedge with req_ready expected high; returns at the
  // negedge of cycle N+2 (cycle 1 = first cycle after the accept edge).
  task automatic run_op(input logic w, input logic [1:0] len, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, input string tag);
    int          n;
    int          k;
    int          resp_cnt;
    logic        e;
    logic [31:0] exp_rd;
    n      = n_beats(len, addr);
    e      = exp_error(len, addr);
    exp_rd = w ? 32'h0 : model_load(len, sgn, addr);
    chk({tag, "/ready_at_req"}, {31'b0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_write   = w;
    req_length  = len;
    req_signed  = sgn;
    req_address = addr;
    req_wdata   = wd;
    resp_cnt    = 0;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clock);
      if (!hold) req_valid = 1'b0;
      if (resp_valid) resp_cnt++;
      if (c <= n) begin
        k = c - 1;
        chk({tag, "/beat_addr"}, {26'b0, bus_address}, (addr + k) % 64);
        chk({tag, "/beat_write"}, {31'b0, bus_write}, {31'b0, w});
        chk({tag, "/beat_read"}, {31'b0, bus_read}, {31'b0, ~w});
        if (w) chk({tag, "/beat_wdata"}, {24'b0, bus_wdata}, (wd >> (8 * (n - 1 - k))) & 32'hFF);
        chk({tag, "/beat_no_resp"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "/beat_not_ready"}, {31'b0, req_ready}, 32'd0);
        if (bus_write) mem[bus_address] = bus_wdata;
      end else if (c == n + 1) begin
        last_rdata = resp_rdata;
        chk({tag, "/resp_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "/resp_rdata"}, resp_rdata, exp_rd);
        chk({tag, "/resp_error"}, {31'b0, resp_error}, {31'b0, e});
        chk({tag, "/done_strobes"}, {30'b0, bus_read, bus_write}, 32'd0);
        chk({tag, "/done_bus"}, {18'b0, bus_address, bus_wdata}, 32'd0);
        chk({tag, "/done_not_ready"}, {31'b0, req_ready}, 32'd0);
      end else begin
        chk({tag, "/after_no_resp"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "/after_ready"}, {31'b0, req_ready}, 32'd1);
      end
    end
    chk({tag, "/resp_count"}, resp_cnt, 32'd1);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_length  = 2'b00;
    req_signed  = 1'b0;
    req_address = 32'h0;
    req_wdata   = 32'h0;
    last_rdata  = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    repeat (2) @(negedge clock);
    chk("reset/ready", {31'b0, req_ready}, 32'd1);
    chk("reset/resp", {30'b0, resp_valid, resp_error}, 32'd0);
    chk("reset/rdata", resp_rdata, 32'd0);
    chk("reset/bus", {16'b0, bus_read, bus_write, bus_address, bus_wdata}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Word store 0x12345678 at 8: beats 8..11 with 12,34,56,78; response in cycle 5.
    run_op(1'b1, 2'b11, 1'b0, 32'd8, 32'h1234_5678, 1'b0, "st_word8");
    chk("st_word8/mem", {mem[8], mem[9], mem[10], mem[11]}, 32'h1234_5678);

    // Half loads of 0xF0,0x0F at 20/21.
    mem[20] = 8'hF0;
    mem[21] = 8'h0F;
    run_op(1'b0, 2'b10, 1'b1, 32'd20, 32'h0, 1'b0, "ld_half_s");
    chk("ld_half_s/value", last_rdata, 32'hFFFF_F00F);
    run_op(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 1'b0, "ld_half_u");
    chk("ld_half_u/value", last_rdata, 32'h0000_F00F);

    // Byte loads of 0x80.
    mem[30] = 8'h80;
    run_op(1'b0, 2'b01, 1'b0, 32'd30, 32'h0, 1'b0, "ld_byte_u");
    chk("ld_byte_u/value", last_rdata, 32'h0000_0080);
    run_op(1'b0, 2'b01, 1'b1, 32'd30, 32'h0, 1'b0, "ld_byte_s");
    chk("ld_byte_s/value", last_rdata, 32'hFFFF_FF80);

    // Half store 0xAABB at 63 (wraps to 0 unless misalignment is rejected).
    mem[63] = 8'h00;
    mem[0]  = 8'h00;
    run_op(1'b1, 2'b10, 1'b0, 32'd63, 32'h0000_AABB, 1'b0, "st_half63");
`ifdef LSU_MISALIGN_CHECK_EN
    chk("st_half63/mem", {16'b0, mem[63], mem[0]}, 32'h0000_0000);
`else
    chk("st_half63/mem", {16'b0, mem[63], mem[0]}, 32'h0000_AABB);
`endif

    // Zero-length accesses: no beats, rdata 0.
    run_op(1'b0, 2'b00, 1'b1, 32'd5, 32'h0, 1'b0, "ld_none");
    run_op(1'b1, 2'b00, 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b0, "st_none");

    // req_valid held high: one response, next accept at the end of cycle N+2.
    run_op(1'b0, 2'b11, 1'b0, 32'd4, 32'h0, 1'b1, "ld_hold");
    run_op(1'b0, 2'b01, 1'b1, 32'd30, 32'h0, 1'b0, "ld_after_hold");

    // Reset during beat 2 of a word store.
    for (int i = 40; i < 44; i++) mem[i] = 8'h00;
    chk("rst_xfer/ready_at_req", {31'b0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_length  = 2'b11;
    req_signed  = 1'b0;
    req_address = 32'd40;
    req_wdata   = 32'h1234_5678;
    @(negedge clock);
    req_valid = 1'b0;
    chk("rst_xfer/beat1", {24'b0, bus_wdata}, 32'h12);
    if (bus_write) mem[bus_address] = bus_wdata;
    @(negedge clock);
    chk("rst_xfer/beat2", {24'b0, bus_wdata}, 32'h34);
    if (bus_write) mem[bus_address] = bus_wdata;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_xfer/strobes_low", {30'b0, bus_read, bus_write}, 32'd0);
    chk("rst_xfer/no_resp", {31'b0, resp_valid}, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("rst_xfer/idle_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_xfer/idle_quiet", {29'b0, resp_valid, bus_read, bus_write}, 32'd0);
      if (bus_write) mem[bus_address] = bus_wdata;
    end
    chk("rst_xfer/mem", {mem[40], mem[41], mem[42], mem[43]}, 32'h1234_0000);

    // Randomised accesses against the memory model.
    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) && (i != 39), "rand");
    end
    req_valid = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
